// File: rtl/mips16_byte_loader.sv
// Byte-serial instruction-memory loader and run controller for a small MIPS16-style core.
// Optional feature macro LOADER_CHECKSUM_EN: running XOR checksum of accepted data bytes on chk.
module mips16_byte_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic              in_cmd,
  input  logic [7:0]        in_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [7:0]        chk
);

  localparam int AB = (ADDR_W + 7) / 8;
  localparam int WB = DATA_W / 8;
  localparam logic [1:0] A_LAST = 2'(AB - 1);
  localparam logic [1:0] W_LAST = 2'(WB - 1);

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_HALT = 8'h03;
  localparam logic [7:0] CMD_STEP = 8'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          acnt, acnt_nxt;
  logic [1:0]          bcnt, bcnt_nxt;
  logic [DATA_W-1:0]   word, word_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                we_nxt;
  logic                step;
  logic                err_nxt;
  logic                run_nxt;
  logic                busy_nxt;
  logic                accept;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_sum, chk_nxt;
  assign chk = chk_sum;
`else
  assign chk = 8'h00;
`endif

  assign accept = ena & in_valid;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt = state;
    acnt_nxt  = acnt;
    bcnt_nxt  = bcnt;
    word_nxt  = word;
    // The address advances on the edge that closes the write pulse.
    addr_nxt  = mem_we ? (mem_addr + ADDR_W'(1)) : mem_addr;
    wdata_nxt = mem_wdata;
    we_nxt    = 1'b0;
    step      = 1'b0;
    err_nxt   = err;
`ifdef LOADER_CHECKSUM_EN
    chk_nxt   = chk_sum;
`endif
    if (accept) begin
      if (in_cmd) begin
        case (in_byte)
          CMD_LOAD: begin
            state_nxt = ADDR;
            acnt_nxt  = 2'd0;
            bcnt_nxt  = 2'd0;
            word_nxt  = '0;
            err_nxt   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_nxt   = 8'h00;
`endif
          end
          CMD_RUN: begin
            state_nxt = RUN;
            bcnt_nxt  = 2'd0;
            word_nxt  = '0;
          end
          CMD_HALT: begin
            state_nxt = IDLE;
            bcnt_nxt  = 2'd0;
            word_nxt  = '0;
          end
          CMD_STEP: begin
            if (state == IDLE) begin
              step = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
          default: err_nxt = 1'b1;
        endcase
      end else begin
        case (state)
          ADDR: begin
            addr_nxt = ADDR_W'({mem_addr, in_byte});
`ifdef LOADER_CHECKSUM_EN
            chk_nxt  = chk_sum ^ in_byte;
`endif
            if (acnt == A_LAST) begin
              state_nxt = DATA;
              acnt_nxt  = 2'd0;
            end else begin
              acnt_nxt  = acnt + 2'd1;
            end
          end
          DATA: begin
`ifdef LOADER_CHECKSUM_EN
            chk_nxt = chk_sum ^ in_byte;
`endif
            if (bcnt == W_LAST) begin
              wdata_nxt = DATA_W'({word, in_byte});
              we_nxt    = 1'b1;
              bcnt_nxt  = 2'd0;
              word_nxt  = '0;
            end else begin
              word_nxt  = DATA_W'({word, in_byte});
              bcnt_nxt  = bcnt + 2'd1;
            end
          end
          default: err_nxt = 1'b1;
        endcase
      end
    end else begin
      state_nxt = state;
    end
    run_nxt  = (state_nxt == RUN) | step;
    busy_nxt = (state_nxt == ADDR) | (state_nxt == DATA);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acnt      <= 2'd0;
      bcnt      <= 2'd0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acnt      <= acnt_nxt;
      bcnt      <= bcnt_nxt;
      word      <= word_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      cpu_run   <= run_nxt;
      busy      <= busy_nxt;
      err       <= err_nxt;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sum <= 8'h00;
    end else begin
      chk_sum <= chk_nxt;
    end
  end
`endif

endmodule

// File: doc/mips16_byte_loader.md
MIPS16_BYTE_LOADER -- requirements
Module: mips16_byte_loader

Interface
REQ-001 Parameter DATA_W, default 16: instruction word width in bits; SHALL be a multiple of 8, range 8..32.
REQ-002 Parameter ADDR_W, default 8: memory address width in bits, range 1..16; AB = ceil(ADDR_W/8) address bytes.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  when low, in_valid is ignored and all state holds; mem_we and step pulses are forced low.
REQ-006 in_valid  input  1  single-cycle byte strobe.
REQ-007 in_cmd  input  1  qualifies in_byte: 1 = command byte, 0 = data byte.
REQ-008 in_byte  input  8  byte payload.
REQ-009 mem_we  output  1  one-cycle instruction-memory write pulse.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  DATA_W  write data.
REQ-012 cpu_run  output  1  processor clock-enable.
REQ-013 busy  output  1  high in the ADDR and DATA states.
REQ-014 err  output  1  sticky protocol-error flag.
REQ-015 chk  output  8  running XOR checksum (see Configuration).

Function
REQ-016 States: IDLE, ADDR, DATA, RUN; a byte is accepted only when in_valid and ena are both high.
REQ-017 Command 0x01 LOAD, any state: clear err, the address byte count, and the partial word; drop cpu_run; go to ADDR.
REQ-018 ADDR: accept AB data bytes MSB-first into mem_addr, keeping the low ADDR_W bits; after the last byte go to DATA.
REQ-019 DATA: pack data bytes MSB-first into a DATA_W/8-byte word.
REQ-020 When a word completes, mem_wdata SHALL hold it and mem_we SHALL pulse for exactly the following cycle; mem_addr increments on the cycle after the pulse.
REQ-021 Address increment SHALL wrap from 2^ADDR_W-1 to 0 with no error.
REQ-022 Command 0x02 RUN, any state: go to RUN with cpu_run=1; a partial word is discarded with no write and no error.
REQ-023 Command 0x03 HALT, any state: go to IDLE with cpu_run=0; a partial word is discarded.
REQ-024 Command 0x04 STEP, valid only in IDLE: cpu_run=1 for exactly one cycle; state stays IDLE.
REQ-025 Set err and leave the state unchanged for any of:
  - an unknown command code;
  - STEP outside IDLE;
  - a data byte in IDLE or RUN.
REQ-026 The write of a word that completed on the previous cycle SHALL still occur if a command arrives in the pulse cycle.
REQ-027 No combinational path SHALL exist from any input to any output; all outputs are registered.

Reset
REQ-028 rst_n low, asynchronous and at any time including mid-word, SHALL force:
  - state IDLE;
  - mem_we=0, mem_addr=0, mem_wdata=0;
  - cpu_run=0, busy=0, err=0, chk=0;
  - internal byte counters cleared.
REQ-029 The first byte accepted after rst_n deasserts SHALL be processed from IDLE.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: chk XORs every data byte accepted in ADDR or DATA, and is cleared by LOAD.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: chk is constant 0 and no checksum register exists; all other behaviour is identical.

Verification
REQ-032 Default params: cmd 0x01, data 0x10, 0x12, 0x34 -> exactly one mem_we with addr 0x10, wdata 0x1234; then mem_addr=0x11.
REQ-033 ADDR_W=8: LOAD at 0xFF, then 4 data bytes -> writes at 0xFF then 0x00.
REQ-034 LOAD, addr 0x00, data 0xAB, then cmd 0x02 -> no mem_we, cpu_run=1, err=0.
REQ-035 From IDLE: data byte 0x55 -> err=1; then cmd 0x07 -> err stays 1; then LOAD -> err=0.
REQ-036 STEP in IDLE -> cpu_run high exactly 1 cycle; rst_n pulsed low after 1 of 2 data bytes -> all outputs 0 immediately; a new LOAD works.
REQ-037 With LOADER_CHECKSUM_EN defined: LOAD, bytes 0x10, 0x12, 0x34 -> chk=0x36; without the macro -> chk=0x00.
